// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared opcodes, fetch defaults and fetch-stage state type
package cpu_pkg;

  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;

  localparam logic [31:0] DEFAULT_NOP_INST = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    HOLD
  } if_state_t;

endpackage

// File: rtl/if_stage_if.sv
// rtl/if_stage_if.sv - instruction memory, redirect, stall and IF/ID signals of the fetch stage
interface if_stage_if #(
  parameter int PC_WIDTH = 32
);

  logic                imem_req;
  logic [PC_WIDTH-1:0] imem_addr;
  logic                imem_ready;
  logic [31:0]         imem_rdata;
  logic                branch_taken;
  logic [PC_WIDTH-1:0] branch_target;
  logic                stall;
  logic                ifid_valid;
  logic [PC_WIDTH-1:0] ifid_pc;
  logic [31:0]         ifid_inst;
  logic [6:0]          ifid_opcode;

  modport master (
    output imem_req, imem_addr, ifid_valid, ifid_pc, ifid_inst, ifid_opcode,
    input  imem_ready, imem_rdata, branch_taken, branch_target, stall
  );

  modport slave (
    input  imem_req, imem_addr, ifid_valid, ifid_pc, ifid_inst, ifid_opcode,
    output imem_ready, imem_rdata, branch_taken, branch_target, stall
  );

endinterface

// File: rtl/if_stage_ifid_reg.sv
// rtl/if_stage_ifid_reg.sv - IF/ID pipeline register with kill > hold > load > bubble priority
module ifid_reg #(
  parameter int          PC_WIDTH = 32,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                kill,
  input  logic                stall,
  input  logic                load,
  input  logic [PC_WIDTH-1:0] load_pc,
  input  logic [31:0]         load_inst,
  output logic                valid,
  output logic [PC_WIDTH-1:0] pc,
  output logic [31:0]         inst
);

  logic                valid_q, valid_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic [31:0]         inst_q, inst_d;

  always_comb begin
    valid_d = valid_q;
    pc_d    = pc_q;
    inst_d  = inst_q;
    if (kill) begin
      valid_d = 1'b0;
      inst_d  = NOP_INST;
    end else if (stall && valid_q) begin
      // a stalled bubble carries nothing worth holding, so it may be overwritten
      valid_d = valid_q;
    end else if (load) begin
      valid_d = 1'b1;
      pc_d    = load_pc;
      inst_d  = load_inst;
    end else begin
      valid_d = 1'b0;
      inst_d  = NOP_INST;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      pc_q    <= '0;
      inst_q  <= NOP_INST;
    end else begin
      valid_q <= valid_d;
      pc_q    <= pc_d;
      inst_q  <= inst_d;
    end
  end

  assign valid = valid_q;
  assign pc    = pc_q;
  assign inst  = inst_q;

endmodule

// File: rtl/if_stage.sv
// rtl/if_stage.sv - instruction fetch: PC, imem handshake, branch redirect and one-entry skid
module if_stage
  import cpu_pkg::*;
#(
  parameter int                  PC_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0] RESET_PC = PC_WIDTH'(DEFAULT_RESET_PC),
  parameter logic [31:0]         NOP_INST = DEFAULT_NOP_INST
) (
  input  logic          clk,
  input  logic          rst,
  if_stage_if.master    bus
);

  if_state_t           state_q, state_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic                pend_redir_q, pend_redir_d;
  logic [PC_WIDTH-1:0] pend_tgt_q, pend_tgt_d;
  logic                skid_valid_q, skid_valid_d;
  logic [PC_WIDTH-1:0] skid_pc_q, skid_pc_d;
  logic [31:0]         skid_inst_q, skid_inst_d;

  logic                fetch_addr_ok;
  logic [PC_WIDTH-1:0] fetch_addr;
  logic                load;
  logic [PC_WIDTH-1:0] load_pc;
  logic [31:0]         load_inst;
  logic                ifid_valid;

  assign fetch_addr    = {pc_q[PC_WIDTH-1:2], 2'b00};
  assign fetch_addr_ok = (state_q == FETCH);

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    pend_redir_d = pend_redir_q;
    pend_tgt_d   = pend_tgt_q;
    skid_valid_d = skid_valid_q;
    skid_pc_d    = skid_pc_q;
    skid_inst_d  = skid_inst_q;
    load         = 1'b0;
    load_pc      = fetch_addr;
    load_inst    = bus.imem_rdata;
    case (state_q)
      IDLE: begin
        state_d = FETCH;
        if (bus.branch_taken) pc_d = bus.branch_target;
      end
      FETCH: begin
        if (!bus.imem_ready) begin
          if (bus.branch_taken) begin
            pend_redir_d = 1'b1;
            pend_tgt_d   = bus.branch_target;
          end
        end else if (bus.branch_taken || pend_redir_q) begin
          // response belongs to the wrong path; refetch from the redirect
          pc_d         = bus.branch_taken ? bus.branch_target : pend_tgt_q;
          pend_redir_d = 1'b0;
        end else if (bus.stall && ifid_valid) begin
          skid_valid_d = 1'b1;
          skid_pc_d    = fetch_addr;
          skid_inst_d  = bus.imem_rdata;
          pc_d         = pc_q + PC_WIDTH'(4);
          state_d      = HOLD;
        end else begin
          load = 1'b1;
          pc_d = pc_q + PC_WIDTH'(4);
        end
      end
      HOLD: begin
        if (bus.branch_taken) begin
          skid_valid_d = 1'b0;
          pc_d         = bus.branch_target;
          state_d      = FETCH;
        end else if (!bus.stall && skid_valid_q) begin
          load         = 1'b1;
          load_pc      = skid_pc_q;
          load_inst    = skid_inst_q;
          skid_valid_d = 1'b0;
          state_d      = FETCH;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      pc_q         <= RESET_PC;
      pend_redir_q <= 1'b0;
      pend_tgt_q   <= '0;
      skid_valid_q <= 1'b0;
      skid_pc_q    <= '0;
      skid_inst_q  <= NOP_INST;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      pend_redir_q <= pend_redir_d;
      pend_tgt_q   <= pend_tgt_d;
      skid_valid_q <= skid_valid_d;
      skid_pc_q    <= skid_pc_d;
      skid_inst_q  <= skid_inst_d;
    end
  end

  ifid_reg #(
    .PC_WIDTH (PC_WIDTH),
    .NOP_INST (NOP_INST)
  ) u_ifid_reg (
    .clk       (clk),
    .rst       (rst),
    .kill      (bus.branch_taken),
    .stall     (bus.stall),
    .load      (load),
    .load_pc   (load_pc),
    .load_inst (load_inst),
    .valid     (ifid_valid),
    .pc        (bus.ifid_pc),
    .inst      (bus.ifid_inst)
  );

  assign bus.imem_req    = fetch_addr_ok;
  assign bus.imem_addr   = fetch_addr;
  assign bus.ifid_valid  = ifid_valid;
  assign bus.ifid_opcode = bus.ifid_inst[6:0];

endmodule

// File: tb/tb_if_stage.sv
// tb/tb_if_stage.sv - directed vector table, wrap/reset sequence and randomized model comparison
module tb_if_stage;
  import cpu_pkg::*;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   failures = 0;

  if_stage_if #(.PC_WIDTH(32)) bus();

  if_stage #(.PC_WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rdy;
    logic [31:0] rdata;
    logic        br;
    logic [31:0] tgt;
    logic        stall;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_ifv;
    logic [31:0] e_ifpc;
    logic [31:0] e_inst;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mk(logic rdy, logic [31:0] rdata, logic br, logic [31:0] tgt, logic stall,
                              logic e_req, logic [31:0] e_addr, logic e_ifv, logic [31:0] e_ifpc,
                              logic [31:0] e_inst);
    vec_t v;
    v.rdy = rdy; v.rdata = rdata; v.br = br; v.tgt = tgt; v.stall = stall;
    v.e_req = e_req; v.e_addr = e_addr; v.e_ifv = e_ifv; v.e_ifpc = e_ifpc; v.e_inst = e_inst;
    return v;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic drive(logic r, logic rdy, logic [31:0] rdata, logic br, logic [31:0] tgt, logic st);
    rst = r; bus.imem_ready = rdy; bus.imem_rdata = rdata;
    bus.branch_taken = br; bus.branch_target = tgt; bus.stall = st;
  endtask

  task automatic chk_outs(string tag, logic e_req, logic [31:0] e_addr, logic e_ifv,
                          logic [31:0] e_ifpc, logic [31:0] e_inst);
    logic [31:0] inst_v;
    inst_v = e_inst;
    chk({tag, "_req"},    32'(bus.imem_req),    32'(e_req));
    chk({tag, "_addr"},   bus.imem_addr,        e_addr);
    chk({tag, "_ifv"},    32'(bus.ifid_valid),  32'(e_ifv));
    chk({tag, "_ifpc"},   bus.ifid_pc,          e_ifpc);
    chk({tag, "_inst"},   bus.ifid_inst,        e_inst);
    chk({tag, "_opcode"}, 32'(bus.ifid_opcode), 32'(inst_v[6:0]));
  endtask

  // Reference model: the stage seen as "started?", a fetch pointer, a pending-redirect
  // queue (at most one, newest wins) and a skid queue (nonempty means fetching is parked).
  bit          m_run;
  logic [31:0] m_pc;
  logic [31:0] m_redir[$];
  logic [63:0] m_skid[$];
  bit          m_ifv;
  logic [31:0] m_ifpc, m_ifinst;

  function automatic logic [31:0] mem_word(logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  task automatic model_step(logic r, logic rdy, logic [31:0] rdata, logic br, logic [31:0] tgt, logic st);
    logic        have_new;
    logic [63:0] nw;
    logic [31:0] fa;
    fa = {m_pc[31:2], 2'b00};
    have_new = 1'b0;
    nw = '0;
    if (r) begin
      m_run = 0; m_pc = DEFAULT_RESET_PC; m_redir.delete(); m_skid.delete();
      m_ifv = 0; m_ifpc = 0; m_ifinst = NOP;
      return;
    end
    if (!m_run) begin
      m_run = 1;
      if (br) m_pc = tgt;
    end else if (m_skid.size() != 0) begin
      if (br) begin m_skid.delete(); m_pc = tgt; end
      else if (!st) begin nw = m_skid.pop_front(); have_new = 1'b1; end
    end else if (!rdy) begin
      if (br) begin m_redir.delete(); m_redir.push_back(tgt); end
    end else if (br || m_redir.size() != 0) begin
      m_pc = br ? tgt : m_redir[0];
      m_redir.delete();
    end else begin
      m_pc = fa + 32'd4;
      if (st && m_ifv) m_skid.push_back({rdata, fa});
      else begin nw = {rdata, fa}; have_new = 1'b1; end
    end
    if (br) begin
      m_ifv = 0; m_ifinst = NOP;
    end else if (st && m_ifv) begin
      m_ifv = 1;
    end else if (have_new) begin
      m_ifv = 1; m_ifinst = nw[63:32]; m_ifpc = nw[31:0];
    end else begin
      m_ifv = 0; m_ifinst = NOP;
    end
  endtask

  initial begin
    drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    @(negedge clk);
    chk_outs("reset", 1'b0, DEFAULT_RESET_PC, 1'b0, 32'h0, NOP);
    chk("reset_nop_is_imm", 32'(bus.ifid_opcode), 32'(OP_IMM));

    vt.push_back(mk(1, 32'h0050_0093, 0, 0, 0,      0, 32'h0,   0, 32'h0,   NOP));
    vt.push_back(mk(1, 32'h0050_0093, 0, 0, 0,      1, 32'h0,   0, 32'h0,   NOP));
    vt.push_back(mk(1, 32'h00A0_0113, 0, 0, 0,      1, 32'h4,   1, 32'h0,   32'h0050_0093));
    vt.push_back(mk(0, 32'h0, 0, 0, 0,              1, 32'h8,   1, 32'h4,   32'h00A0_0113));
    vt.push_back(mk(0, 32'h0, 0, 0, 0,              1, 32'h8,   0, 32'h4,   NOP));
    vt.push_back(mk(0, 32'h0, 0, 0, 0,              1, 32'h8,   0, 32'h4,   NOP));
    vt.push_back(mk(1, 32'h00C0_0193, 0, 0, 0,      1, 32'h8,   0, 32'h4,   NOP));
    vt.push_back(mk(1, 32'h0000_A103, 0, 0, 1,      1, 32'hC,   1, 32'h8,   32'h00C0_0193));
    vt.push_back(mk(0, 32'h0, 0, 0, 1,              0, 32'h10,  1, 32'h8,   32'h00C0_0193));
    vt.push_back(mk(0, 32'h0, 0, 0, 0,              0, 32'h10,  1, 32'h8,   32'h00C0_0193));
    vt.push_back(mk(0, 32'h0, 0, 0, 0,              1, 32'h10,  1, 32'hC,   32'h0000_A103));
    vt.push_back(mk(1, 32'h0000_0033, 0, 0, 0,      1, 32'h10,  0, 32'hC,   NOP));
    vt.push_back(mk(0, 32'h0, 1, 32'h40, 0,         1, 32'h14,  1, 32'h10,  32'h0000_0033));
    vt.push_back(mk(0, 32'h0, 0, 0, 0,              1, 32'h14,  0, 32'h10,  NOP));
    vt.push_back(mk(1, 32'hDEAD_BEEF, 0, 0, 0,      1, 32'h14,  0, 32'h10,  NOP));
    vt.push_back(mk(1, 32'h0010_8093, 0, 0, 0,      1, 32'h40,  0, 32'h10,  NOP));
    vt.push_back(mk(1, 32'h1111_1111, 1, 32'h102, 1, 1, 32'h44, 1, 32'h40,  32'h0010_8093));
    vt.push_back(mk(0, 32'h0, 0, 0, 1,              1, 32'h100, 0, 32'h40,  NOP));
    vt.push_back(mk(1, 32'h2222_2222, 0, 0, 0,      1, 32'h100, 0, 32'h40,  NOP));
    vt.push_back(mk(0, 32'h0, 0, 0, 0,              1, 32'h104, 1, 32'h100, 32'h2222_2222));
    vt.push_back(mk(0, 32'h0, 0, 0, 0,              1, 32'h104, 0, 32'h100, NOP));

    for (int i = 0; i < vt.size(); i++) begin
      if (i != 0) @(negedge clk);
      drive(1'b0, vt[i].rdy, vt[i].rdata, vt[i].br, vt[i].tgt, vt[i].stall);
      chk_outs($sformatf("vec%0d", i), vt[i].e_req, vt[i].e_addr, vt[i].e_ifv, vt[i].e_ifpc, vt[i].e_inst);
    end

    // PC wrap at the top of the address space, then reset in the middle of a waiting fetch
    @(negedge clk); drive(1'b0, 1'b1, 32'h0, 1'b1, 32'hFFFF_FFFC, 1'b0);
    @(negedge clk); drive(1'b0, 1'b1, 32'h0000_0093, 1'b0, 32'h0, 1'b0);
    chk("wrap_addr_top", bus.imem_addr, 32'hFFFF_FFFC);
    @(negedge clk); drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    chk_outs("wrap", 1'b1, 32'h0, 1'b1, 32'hFFFF_FFFC, 32'h0000_0093);
    @(negedge clk); drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    @(negedge clk); drive(1'b0, 1'b1, 32'h1234_5678, 1'b0, 32'h0, 1'b0);
    chk_outs("post_rst", 1'b0, DEFAULT_RESET_PC, 1'b0, 32'h0, NOP);
    @(negedge clk); drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    chk_outs("refetch", 1'b1, DEFAULT_RESET_PC, 1'b0, 32'h0, NOP);

    // randomized traffic against the reference model
    @(negedge clk); drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    model_step(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    for (int c = 0; c < 3000; c++) begin
      logic        r, rdy, br, st;
      logic [31:0] tgt, rdata;
      @(negedge clk);
      r     = ($urandom_range(0, 199) == 0);
      rdy   = ($urandom_range(0, 1) == 1);
      br    = ($urandom_range(0, 9) == 0);
      st    = ($urandom_range(0, 2) == 0);
      tgt   = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
      rdata = rdy ? mem_word({m_pc[31:2], 2'b00}) : $urandom;
      drive(r, rdy, rdata, br, tgt, st);
      chk_outs($sformatf("rnd%0d", c), m_run && (m_skid.size() == 0), {m_pc[31:2], 2'b00},
               m_ifv, m_ifpc, m_ifinst);
      if (m_ifv) chk($sformatf("rnd%0d_memdata", c), bus.ifid_inst, mem_word(m_ifpc));
      model_step(r, rdy, rdata, br, tgt, st);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
